// File: rtl/jtframe_dwnld_pack_if.sv
// Download-stream and SDRAM programming-port bundle for jtframe_dwnld_pack.
// The master side is the packer itself; the slave side is the surrounding top level.
interface jtframe_dwnld_pack_if #(
  parameter int SDRAMW = 22
);
  logic              downloading;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_data;
  logic              ioctl_wr;
  logic [SDRAMW-1:0] prog_addr;
  logic [1:0]        prog_ba;
  logic [15:0]       prog_data;
  logic [1:0]        prog_mask;
  logic              prog_we;
  logic              prog_rdy;
  logic              dwnld_busy;
  logic              ovf;

  modport master (
    input  downloading, ioctl_addr, ioctl_data, ioctl_wr, prog_rdy,
    output prog_addr, prog_ba, prog_data, prog_mask, prog_we, dwnld_busy, ovf
  );

  modport slave (
    output downloading, ioctl_addr, ioctl_data, ioctl_wr, prog_rdy,
    input  prog_addr, prog_ba, prog_data, prog_mask, prog_we, dwnld_busy, ovf
  );
endinterface

// File: rtl/jtframe_dwnld_pack.sv
// Packs the ioctl byte stream into byte-masked 16-bit SDRAM writes through a
// decode register, a small FIFO and a prog_we/prog_rdy output stage.
module jtframe_dwnld_pack #(
  parameter int          SDRAMW    = 22,
  parameter logic [24:0] BA1_START = 25'h08_0000,
  parameter logic [24:0] BA2_START = 25'h10_0000,
  parameter logic [24:0] BA3_START = 25'h18_0000,
  parameter int          FIFO_AW   = 2,
  parameter bit          SWAB      = 1'b0
) (
  input  logic                clk_rom,
  input  logic                rst_n,
  jtframe_dwnld_pack_if.master bus
);
  localparam int               EW      = SDRAMW + 12;
  localparam int               DEPTH   = 2**FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic [1:0]        w_ba;
  logic [24:0]       w_start;
  logic [24:0]       w_off;
  logic [SDRAMW-1:0] w_word;
  logic [1:0]        w_mask;
  logic              w_unused_off;

  logic              r_vld_p1;
  logic [1:0]        r_ba_p1;
  logic [SDRAMW-1:0] r_addr_p1;
  logic [7:0]        r_data_p1;
  logic [1:0]        r_mask_p1;

  logic [EW-1:0]      r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_cnt;
  logic [EW-1:0]      w_head;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_pop;
  logic              w_push;
  logic              w_strobe;
  logic              w_blocked;
  logic              w_load;
  logic              w_drop;
  logic              w_empty;
  logic              w_full;

  logic [SDRAMW-1:0] r_prog_addr;
  logic [1:0]        r_prog_ba;
  logic [15:0]       r_prog_data;
  logic [1:0]        r_prog_mask;
  logic              r_busy;
  logic              r_ovf;
  logic              r_dl_d;

  always_comb begin
    w_ba    = 2'd0;
    w_start = 25'd0;
    if (bus.ioctl_addr >= BA3_START) begin
      w_ba    = 2'd3;
      w_start = BA3_START;
    end else if (bus.ioctl_addr >= BA2_START) begin
      w_ba    = 2'd2;
      w_start = BA2_START;
    end else if (bus.ioctl_addr >= BA1_START) begin
      w_ba    = 2'd1;
      w_start = BA1_START;
    end
  end

  assign w_off        = bus.ioctl_addr - w_start;
  assign w_word       = w_off[SDRAMW:1];
  assign w_mask       = (w_off[0] ^ SWAB) ? 2'b01 : 2'b10;
  assign w_unused_off = ^w_off[24:SDRAMW+1];

  assign w_strobe  = bus.ioctl_wr & bus.downloading;
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == DEPTH_C);
  assign w_push    = r_vld_p1 & (~w_full | w_pop);
  // A decoded byte that cannot enter the FIFO waits here; a new strobe behind it is lost.
  assign w_blocked = r_vld_p1 & ~w_push;
  assign w_load    = w_strobe & ~w_blocked;
  assign w_drop    = w_strobe & w_blocked;
  assign w_head    = r_mem[r_rptr];

  // decode stage (p1)
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n)      r_vld_p1 <= 1'b0;
    else if (w_load) r_vld_p1 <= 1'b1;
    else if (w_push) r_vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk_rom) begin
    if (w_load) begin
      r_ba_p1   <= w_ba;
      r_addr_p1 <= w_word;
      r_data_p1 <= bus.ioctl_data;
      r_mask_p1 <= w_mask;
    end
  end

  // FIFO stage
  always_ff @(posedge clk_rom) begin
    if (w_push) r_mem[r_wptr] <= {r_ba_p1, r_addr_p1, r_data_p1, r_mask_p1};
  end

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + {{FIFO_AW{1'b0}}, w_push} - {{FIFO_AW{1'b0}}, w_pop};
    end
  end

  // output stage
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.prog_rdy) begin
          if (!w_empty) w_pop       = 1'b1;
          else          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      r_prog_addr <= '0;
      r_prog_ba   <= 2'd0;
      r_prog_data <= 16'd0;
      r_prog_mask <= 2'b11;
    end else if (w_pop) begin
      r_prog_ba   <= w_head[EW-1 -: 2];
      r_prog_addr <= w_head[SDRAMW+9:10];
      r_prog_data <= {2{w_head[9:2]}};
      r_prog_mask <= w_head[1:0];
    end else if (r_state == S_WAIT && w_state_nxt == S_IDLE) begin
      r_prog_mask <= 2'b11;
    end
  end

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_ovf  <= 1'b0;
      r_dl_d <= 1'b0;
    end else begin
      r_busy <= bus.downloading | r_vld_p1 | ~w_empty | (r_state == S_WAIT);
      r_dl_d <= bus.downloading;
      if (w_drop)                            r_ovf <= 1'b1;
      else if (bus.downloading && !r_dl_d)   r_ovf <= 1'b0;
    end
  end

  assign bus.prog_addr  = r_prog_addr;
  assign bus.prog_ba    = r_prog_ba;
  assign bus.prog_data  = r_prog_data;
  assign bus.prog_mask  = r_prog_mask;
  assign bus.prog_we    = (r_state == S_WAIT);
  assign bus.dwnld_busy = r_busy;
  assign bus.ovf        = r_ovf;
endmodule

// File: tb/tb_jtframe_dwnld_pack.sv
// Directed bench for jtframe_dwnld_pack: expected writes are queued at each strobe
// and matched against every acknowledged prog_we.
module tb_jtframe_dwnld_pack;
  localparam int SDRAMW = 22;

  logic clk = 1'b0;
  logic rst_n;

  int checks  = 0;
  int errors  = 0;
  int n_wr    = 0;
  int n_exp   = 0;
  int we_hi   = 0;
  int we_rise = 0;
  int rdy_mode = 0;
  int wcnt    = 0;
  logic prev_we = 1'b0;
  logic [63:0] sb [$];

  jtframe_dwnld_pack_if #(.SDRAMW(SDRAMW)) bus ();
  jtframe_dwnld_pack_if #(.SDRAMW(SDRAMW)) bus2 ();

  jtframe_dwnld_pack #(.SDRAMW(SDRAMW), .SWAB(1'b0)) dut (
    .clk_rom (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  jtframe_dwnld_pack #(.SDRAMW(SDRAMW), .SWAB(1'b1)) dut_swab (
    .clk_rom (clk),
    .rst_n   (rst_n),
    .bus     (bus2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ent(input logic [1:0] ba, input logic [21:0] wa,
                                      input logic [7:0] d, input logic [1:0] m);
    return {22'd0, ba, wa, d, d, m};
  endfunction

  function automatic logic [63:0] model(input logic [24:0] a, input logic [7:0] d, input bit swab);
    logic [1:0]  ba;
    logic [24:0] st;
    logic [24:0] off;
    logic [1:0]  m;
    if (a >= 25'h180000)      begin ba = 2'd3; st = 25'h180000; end
    else if (a >= 25'h100000) begin ba = 2'd2; st = 25'h100000; end
    else if (a >= 25'h080000) begin ba = 2'd1; st = 25'h080000; end
    else                      begin ba = 2'd0; st = 25'h0; end
    off = a - st;
    m   = (off[0] ^ swab) ? 2'b01 : 2'b10;
    return ent(ba, off[22:1], d, m);
  endfunction

  function automatic logic [63:0] obs1();
    return {22'd0, bus.prog_ba, bus.prog_addr, bus.prog_data, bus.prog_mask};
  endfunction

  function automatic logic [63:0] obs2();
    return {22'd0, bus2.prog_ba, bus2.prog_addr, bus2.prog_data, bus2.prog_mask};
  endfunction

  // Scoreboard: every write that is acknowledged at the coming edge is matched here.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.prog_we) we_hi++;
      if (bus.prog_we && !prev_we) we_rise++;
      prev_we = bus.prog_we;
      if (bus.prog_we && bus.prog_rdy) begin
        n_wr++;
        if (sb.size() != 0) chk("write", obs1(), sb.pop_front());
        else                chk("extra_write", 64'(n_wr), 64'(n_exp));
      end
    end else begin
      prev_we = 1'b0;
    end
  end

  // SDRAM-side responder: 0 = never ack, 1 = ack every cycle, 2 = ack 3 cycles after prog_we.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      1: bus.prog_rdy = 1'b1;
      2: begin
        if (bus.prog_rdy) begin
          bus.prog_rdy = 1'b0;
          wcnt = 0;
        end else if (bus.prog_we) begin
          wcnt++;
          if (wcnt == 3) bus.prog_rdy = 1'b1;
        end
      end
      default: begin
        bus.prog_rdy = 1'b0;
        wcnt = 0;
      end
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [24:0] a, input logic [7:0] d);
    bus.ioctl_addr = a;
    bus.ioctl_data = d;
    bus.ioctl_wr   = 1'b1;
    tick(1);
    bus.ioctl_wr   = 1'b0;
  endtask

  task automatic expect_wr(input logic [63:0] e);
    sb.push_back(e);
    n_exp++;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!bus.prog_we && sb.size() == 0) break;
      tick(1);
    end
    chk({tag, "_queue_empty"}, 64'(sb.size()), 64'd0);
    chk({tag, "_we_low"}, 64'(bus.prog_we), 64'd0);
  endtask

  logic [24:0] bnd_addr [4];
  logic [63:0] bnd_exp  [4];

  initial begin
    bnd_addr = '{25'h07FFFF, 25'h080000, 25'h100001, 25'h180004};
    bnd_exp  = '{ent(2'd0, 22'h3FFFF, 8'h11, 2'b01), ent(2'd1, 22'h0, 8'h22, 2'b10),
                 ent(2'd2, 22'h0, 8'h33, 2'b01), ent(2'd3, 22'h2, 8'h44, 2'b10)};

    rst_n = 1'b0;
    bus.downloading = 1'b0; bus.ioctl_wr = 1'b0; bus.ioctl_addr = '0; bus.ioctl_data = '0;
    bus.prog_rdy = 1'b0;
    bus2.downloading = 1'b0; bus2.ioctl_wr = 1'b0; bus2.ioctl_addr = '0; bus2.ioctl_data = '0;
    bus2.prog_rdy = 1'b0;
    tick(3);
    chk("rst_we",   64'(bus.prog_we),    64'd0);
    chk("rst_mask", 64'(bus.prog_mask),  64'd3);
    chk("rst_bus",  obs1(),              ent(2'd0, 22'd0, 8'd0, 2'b11));
    chk("rst_busy", 64'(bus.dwnld_busy), 64'd0);
    chk("rst_ovf",  64'(bus.ovf),        64'd0);
    rst_n = 1'b1;
    tick(2);

    // single byte, delayed acknowledge
    rdy_mode = 2;
    bus.downloading = 1'b1;
    tick(1);
    expect_wr(ent(2'd0, 22'h1, 8'hA5, 2'b01));
    strobe(25'h000003, 8'hA5);
    chk("t1_we_n0", 64'(bus.prog_we), 64'd0);
    tick(1);
    chk("t1_we_n1", 64'(bus.prog_we), 64'd0);
    tick(1);
    chk("t1_we_n2",   64'(bus.prog_we), 64'd1);
    chk("t1_fields",  obs1(), ent(2'd0, 22'h1, 8'hA5, 2'b01));
    chk("t1_busy_hi", 64'(bus.dwnld_busy), 64'd1);
    tick(3);
    chk("t1_we_fall",  64'(bus.prog_we),   64'd0);
    chk("t1_mask_off", 64'(bus.prog_mask), 64'd3);
    chk("t1_count",    64'(n_wr),          64'd1);
    bus.downloading = 1'b0;
    tick(1);
    chk("t1_busy_lo", 64'(bus.dwnld_busy), 64'd0);

    // bank boundaries
    bus.downloading = 1'b1;
    rdy_mode = 1;
    tick(1);
    for (int k = 0; k < 4; k++) begin
      expect_wr(bnd_exp[k]);
      strobe(bnd_addr[k], 8'(8'h11 * (k + 1)));
      tick(4);
    end
    wait_idle("t2", 40);
    chk("t2_count", 64'(n_wr), 64'd5);

    // back-to-back strobes and writes
    we_hi = 0;
    we_rise = 0;
    for (int k = 0; k < 4; k++) begin
      expect_wr(model(25'h000200 + 25'(k), 8'(8'h10 + k), 1'b0));
      strobe(25'h000200 + 25'(k), 8'(8'h10 + k));
    end
    wait_idle("t3", 40);
    chk("t3_we_rises", 64'(we_rise), 64'd1);
    chk("t3_we_cycles", 64'(we_hi), 64'd4);
    chk("t3_ovf", 64'(bus.ovf), 64'd0);
    chk("t3_count", 64'(n_wr), 64'd9);

    // overflow: six bytes fit (output, four FIFO slots, decode), the seventh is lost
    rdy_mode = 0;
    tick(1);
    for (int k = 0; k < 7; k++) begin
      if (k < 6) expect_wr(model(25'h001000 + 25'(k), 8'(8'h40 + k), 1'b0));
      strobe(25'h001000 + 25'(k), 8'(8'h40 + k));
    end
    tick(2);
    chk("t4_ovf_set", 64'(bus.ovf), 64'd1);
    chk("t4_we_held", 64'(bus.prog_we), 64'd1);
    chk("t4_head", obs1(), model(25'h001000, 8'h40, 1'b0));
    rdy_mode = 1;
    wait_idle("t4", 60);
    chk("t4_count", 64'(n_wr), 64'd15);
    bus.downloading = 1'b0;
    tick(1);
    chk("t4_ovf_sticky", 64'(bus.ovf), 64'd1);
    bus.downloading = 1'b1;
    tick(1);
    chk("t4_ovf_clear", 64'(bus.ovf), 64'd0);

    // drain after downloading falls
    rdy_mode = 0;
    tick(1);
    for (int k = 0; k < 4; k++) begin
      expect_wr(model(25'h0A0100 + 25'(k), 8'(8'hC0 + k), 1'b0));
      strobe(25'h0A0100 + 25'(k), 8'(8'hC0 + k));
    end
    tick(2);
    chk("t5_we_held", 64'(bus.prog_we), 64'd1);
    bus.downloading = 1'b0;
    rdy_mode = 1;
    wait_idle("t5", 40);
    chk("t5_busy_last", 64'(bus.dwnld_busy), 64'd1);
    tick(1);
    chk("t5_busy_lo", 64'(bus.dwnld_busy), 64'd0);
    chk("t5_count", 64'(n_wr), 64'd19);

    // reset while a write is pending with two entries queued
    bus.downloading = 1'b1;
    rdy_mode = 0;
    tick(1);
    for (int k = 0; k < 3; k++) begin
      expect_wr(model(25'h000800 + 25'(k), 8'(8'h70 + k), 1'b0));
      strobe(25'h000800 + 25'(k), 8'(8'h70 + k));
    end
    tick(2);
    chk("t6_we_before", 64'(bus.prog_we), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_we_async",   64'(bus.prog_we),   64'd0);
    chk("t6_mask_async", 64'(bus.prog_mask), 64'd3);
    bus.downloading = 1'b0;
    n_exp = n_exp - sb.size();
    sb.delete();
    tick(3);
    rst_n = 1'b1;
    tick(10);
    chk("t6_no_writes", 64'(n_wr), 64'd19);
    chk("t6_we_idle",   64'(bus.prog_we), 64'd0);
    chk("t6_busy_lo",   64'(bus.dwnld_busy), 64'd0);

    // swapped byte lanes
    bus2.downloading = 1'b1;
    tick(1);
    bus2.ioctl_addr = 25'h000010;
    bus2.ioctl_data = 8'h3C;
    bus2.ioctl_wr   = 1'b1;
    tick(1);
    bus2.ioctl_wr   = 1'b0;
    tick(1);
    chk("t7_we_n1", 64'(bus2.prog_we), 64'd0);
    tick(1);
    chk("t7_we_n2", 64'(bus2.prog_we), 64'd1);
    chk("t7_fields", obs2(), ent(2'd0, 22'h8, 8'h3C, 2'b01));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
